rr_mux_arbiter4: RTL and testbench

- Round-robin arbiter that shares one 4:1, 2-bit-wide datapath select among four requesters.
- Produces the 2-bit mux select (00..11 = requester 0..3) and a one-hot grant.
- Registers the selected requester's 2-bit operand onto a shared output bus.
- Sits between requester units and the shared 2-bit 4:1 multiplexer. Enforces fair access and a bounded hold time.

---
 rtl/rr_mux_arbiter4.sv | 155 +++++++++++++++
 tb/tb_rr_mux_arbiter4.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter4.sv
// Round-robin arbiter for four requesters sharing one 2-bit 4:1 mux.
// It registers a one-hot grant and an encoded select, copies the owner's
// operand onto a shared bus, and forces a release when the hold time
// reaches MAX_HOLD. Every grant is followed by at least one idle cycle.
module rr_mux_arbiter4 #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] req,
   input  logic       done,
   input  logic [1:0] data0,
   input  logic [1:0] data1,
   input  logic [1:0] data2,
   input  logic [1:0] data3,
   output logic [3:0] grant,
   output logic [1:0] sel,
   output logic       busy,
   output logic [1:0] out_data,
   output logic       out_valid,
   output logic       timeout
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       grant_q, grant_d;
   logic [1:0]       sel_q, sel_d;
   logic             busy_q, busy_d;
   logic [1:0]       out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             timeout_q, timeout_d;

   logic [3:0]       req_rot;
   logic [1:0]       win_off;
   logic [1:0]       winner;
   logic [1:0]       owner_data;
   logic             early_rel;
   logic             expired;

   // Rotate requests so bit 0 is the requester at ptr, then find the first set bit
   always_comb begin
      req_rot = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         req_rot[k] = req[ptr_q + 2'(k)];
      end
      if (req_rot[0])      win_off = 2'd0;
      else if (req_rot[1]) win_off = 2'd1;
      else if (req_rot[2]) win_off = 2'd2;
      else                 win_off = 2'd3;
      winner = ptr_q + win_off;
   end

   // Operand of the current owner, as seen through the shared mux
   always_comb begin
      owner_data = data0;
      case (sel_q)
         2'd0: owner_data = data0;
         2'd1: owner_data = data1;
         2'd2: owner_data = data2;
         2'd3: owner_data = data3;
         default: owner_data = data0;
      endcase
   end

   // Next-state and output logic for the IDLE/HOLD controller
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      sel_d       = sel_q;
      busy_d      = busy_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      timeout_d   = 1'b0;
      // done or the owner dropping its request outranks the counter, so a
      // coincident expiry does not report a timeout
      early_rel   = done || !req[sel_q];
      expired     = (cnt_q >= MAX_HOLD_C);

      case (state_q)
         IDLE: begin
            grant_d     = 4'b0000;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
            if (req != 4'b0000) begin
               state_d = HOLD;
               grant_d = 4'b0001 << winner;
               sel_d   = winner;
               busy_d  = 1'b1;
               cnt_d   = CNT_W'(1);
            end
         end
         HOLD: begin
            if (early_rel || expired) begin
               state_d     = IDLE;
               grant_d     = 4'b0000;
               busy_d      = 1'b0;
               out_valid_d = 1'b0;
               ptr_d       = sel_q + 2'd1;
               timeout_d   = !early_rel;
            end else begin
               out_data_d  = owner_data;
               out_valid_d = 1'b1;
               cnt_d       = expired ? cnt_q : cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Register all state; reset clears everything, including a grant in flight
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         ptr_q       <= 2'd0;
         cnt_q       <= '0;
         grant_q     <= 4'b0000;
         sel_q       <= 2'd0;
         busy_q      <= 1'b0;
         out_data_q  <= 2'd0;
         out_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         sel_q       <= sel_d;
         busy_q      <= busy_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         timeout_q   <= timeout_d;
      end
   end

   assign grant     = grant_q;
   assign sel       = sel_q;
   assign busy      = busy_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// Directed bench for rr_mux_arbiter4 built with MAX_HOLD=4.
module tb_rr_mux_arbiter4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] req;
   logic       done;
   logic [1:0] data0, data1, data2, data3;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       busy;
   logic [1:0] out_data;
   logic       out_valid;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   rr_mux_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .done      (done),
      .data0     (data0),
      .data1     (data1),
      .data2     (data2),
      .data3     (data3),
      .grant     (grant),
      .sel       (sel),
      .busy      (busy),
      .out_data  (out_data),
      .out_valid (out_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"},     grant,     4'b0000);
      chk({tag, "_sel"},       sel,       4'd0);
      chk({tag, "_busy"},      busy,      4'd0);
      chk({tag, "_out_data"},  out_data,  4'd0);
      chk({tag, "_out_valid"}, out_valid, 4'd0);
      chk({tag, "_timeout"},   timeout,   4'd0);
   endtask

   initial begin
      logic [3:0] exp_g [5];
      logic [1:0] exp_s [5];
      exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      exp_s = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      reset_n = 1'b0; req = 4'b0000; done = 1'b0;
      data0 = 2'b00; data1 = 2'b01; data2 = 2'b10; data3 = 2'b11;
      tick(); tick();
      chk_all_zero("reset");
      reset_n = 1'b1;
      tick();
      chk("idle_no_req_grant", grant, 4'b0000);

      // Single requester 2, done on its third HOLD cycle
      req = 4'b0100;
      tick();
      chk("r2_grant", grant, 4'b0100);
      chk("r2_sel", sel, 4'd2);
      chk("r2_busy", busy, 4'd1);
      chk("r2_valid_first", out_valid, 4'd0);
      tick();
      chk("r2_out_data", out_data, 4'b0010);
      chk("r2_out_valid", out_valid, 4'd1);
      tick();
      chk("r2_grant_c3", grant, 4'b0100);
      done = 1'b1;
      tick();
      done = 1'b0; req = 4'b0000;
      chk("r2_rel_grant", grant, 4'b0000);
      chk("r2_rel_busy", busy, 4'd0);
      chk("r2_rel_valid", out_valid, 4'd0);
      chk("r2_rel_timeout", timeout, 4'd0);
      chk("r2_rel_sel_kept", sel, 4'd2);
      chk("r2_rel_data_kept", out_data, 4'b0010);

      // ptr=3: 1001 picks 3; dropping req[3] releases without timeout
      req = 4'b1001;
      tick();
      chk("wrap_w3_grant", grant, 4'b1000);
      chk("wrap_w3_sel", sel, 4'd3);
      req = 4'b0001;
      tick();
      chk("drop_rel_grant", grant, 4'b0000);
      chk("drop_rel_timeout", timeout, 4'd0);
      req = 4'b1001;
      tick();
      chk("wrap_w0_grant", grant, 4'b0001);
      chk("wrap_w0_sel", sel, 4'd0);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("w0_rel_grant", grant, 4'b0000);

      // All four requesting: rotation from ptr=1
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("rot%0d_grant", i), grant, exp_g[i]);
         chk($sformatf("rot%0d_sel", i), sel, {2'b00, exp_s[i]});
         chk($sformatf("rot%0d_busy", i), busy, 4'd1);
         tick();
         chk($sformatf("rot%0d_data", i), out_data, {2'b00, exp_s[i]});
         done = 1'b1;
         tick();
         done = 1'b0;
         chk($sformatf("rot%0d_gap", i), grant, 4'b0000);
      end

      // Lone requester 1 held with no done: forced release after 4 HOLD cycles
      req = 4'b0010;
      tick();
      chk("to_grant", grant, 4'b0010);
      tick(); tick(); tick();
      chk("to_c4_grant", grant, 4'b0010);
      chk("to_c4_timeout", timeout, 4'd0);
      tick();
      chk("to_pulse", timeout, 4'd1);
      chk("to_rel_grant", grant, 4'b0000);
      chk("to_rel_busy", busy, 4'd0);
      tick();
      chk("to_regrant", grant, 4'b0010);
      chk("to_pulse_end", timeout, 4'd0);

      // done coincident with counter expiry: no timeout
      tick(); tick(); tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("both_rel_grant", grant, 4'b0000);
      chk("both_timeout", timeout, 4'd0);

      // Reset in the middle of a HOLD
      req = 4'b1000;
      tick();
      chk("pre_rst_grant", grant, 4'b1000);
      tick();
      chk("pre_rst_data", out_data, 4'b0011);
      reset_n = 1'b0;
      tick();
      chk_all_zero("midrst");
      reset_n = 1'b1;
      req = 4'b1001;
      tick();
      chk("post_rst_ptr0", grant, 4'b0001);
      chk("post_rst_timeout", timeout, 4'd0);
      done = 1'b1;
      req = 4'b1000;
      tick();
      done = 1'b0;
      tick();
      chk("post_rst_w3", grant, 4'b1000);
      chk("post_rst_w3_sel", sel, 4'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
